// File: rtl/imx_tap_training_ctrl.sv
// ============================================================================
// imx_tap_training_ctrl : per-lane LVDS tap sweep, eye search and centring.
// Optional macro TAP_TRAIN_EYE_REPORT_EN adds o_eye_width.   Revision 1.0
// ============================================================================
`default_nettype none

module imx_tap_training_ctrl #(
  parameter int         LANE_WIDTH    = 8,
  parameter int         TAP_WIDTH     = 5,
  parameter int         SETTLE_CYCLES = 16,
  parameter int         SAMPLE_CYCLES = 256,
  parameter int         MIN_MATCHES   = 4,
  parameter int         MIN_EYE       = 3,
  parameter logic [7:0] SYNC_WORD     = 8'h7F
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_start,
  input  logic                            i_abort,
  input  logic [8*LANE_WIDTH-1:0]         i_raw_data,
  output logic [TAP_WIDTH*LANE_WIDTH-1:0] o_tap_data,
  output logic                            o_tap_load,
  output logic                            o_busy,
  output logic                            o_done,
`ifdef TAP_TRAIN_EYE_REPORT_EN
  output logic [(TAP_WIDTH+1)*LANE_WIDTH-1:0] o_eye_width,
`endif
  output logic [LANE_WIDTH-1:0]           o_lane_fail
);

  localparam int LW      = (LANE_WIDTH > 1) ? $clog2(LANE_WIDTH) : 1;
  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int MW      = $clog2(SAMPLE_CYCLES + 1);
  localparam int LENW    = TAP_WIDTH + 1;

  localparam logic [CW-1:0]        SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0]        SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);
  localparam logic [MW-1:0]        MATCH_SAT   = MW'(SAMPLE_CYCLES);
  localparam logic [MW-1:0]        MATCH_MIN   = MW'(MIN_MATCHES);
  localparam logic [LENW-1:0]      EYE_MIN     = LENW'(MIN_EYE);
  localparam logic [TAP_WIDTH-1:0] TAP_LAST    = '1;
  localparam logic [LW-1:0]        LANE_LAST   = LW'(LANE_WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_EVAL   = 3'd4;
  localparam logic [2:0] S_FINAL  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]                      state_q, state_d;
  logic [LW-1:0]                   lane_q, lane_d;
  logic [TAP_WIDTH-1:0]            tap_q, tap_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [MW-1:0]                   match_q, match_d;
  logic [TAP_WIDTH-1:0]            cur_start_q, cur_start_d;
  logic [LENW-1:0]                 cur_len_q, cur_len_d;
  logic [TAP_WIDTH-1:0]            best_start_q, best_start_d;
  logic [LENW-1:0]                 best_len_q, best_len_d;
  logic [TAP_WIDTH*LANE_WIDTH-1:0] tap_data_q, tap_data_d;
  logic [LANE_WIDTH-1:0]           lane_fail_q, lane_fail_d;
  logic [TAP_WIDTH-1:0]            centre;
  logic [7:0]                      lane_byte;
`ifdef TAP_TRAIN_EYE_REPORT_EN
  logic [(TAP_WIDTH+1)*LANE_WIDTH-1:0] eye_q, eye_d;
`endif

  assign lane_byte = i_raw_data[8*int'(lane_q) +: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (i_start) state_d = S_LOAD;
      S_LOAD:   state_d = S_SETTLE;
      S_SETTLE: if (cnt_q == SETTLE_LAST) state_d = S_SAMPLE;
      S_SAMPLE: if (cnt_q == SAMPLE_LAST) state_d = S_EVAL;
      S_EVAL:   state_d = (tap_q == TAP_LAST) ? S_FINAL : S_LOAD;
      S_FINAL:  state_d = (lane_q == LANE_LAST) ? S_DONE : S_LOAD;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (i_abort) state_d = S_IDLE;
  end

  always_comb begin
    o_tap_load = (state_q == S_LOAD) || (state_q == S_FINAL);
    o_busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    o_done     = (state_q == S_DONE);
  end

  // Tap bus is written on entry to LOAD/FINAL so it changes with the strobe.
  always_comb begin
    lane_d       = lane_q;
    tap_d        = tap_q;
    cnt_d        = '0;
    match_d      = match_q;
    cur_start_d  = cur_start_q;
    cur_len_d    = cur_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    tap_data_d   = tap_data_q;
    lane_fail_d  = lane_fail_q;
    centre       = '0;
`ifdef TAP_TRAIN_EYE_REPORT_EN
    eye_d        = eye_q;
`endif
    if (!i_abort) begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            lane_d       = '0;
            tap_d        = '0;
            match_d      = '0;
            cur_start_d  = '0;
            cur_len_d    = '0;
            best_start_d = '0;
            best_len_d   = '0;
            lane_fail_d  = '0;
            tap_data_d[TAP_WIDTH-1:0] = '0;
`ifdef TAP_TRAIN_EYE_REPORT_EN
            eye_d        = '0;
`endif
          end
        end
        S_LOAD: match_d = '0;
        S_SETTLE: cnt_d = (cnt_q == SETTLE_LAST) ? '0 : cnt_q + CW'(1);
        S_SAMPLE: begin
          cnt_d = (cnt_q == SAMPLE_LAST) ? '0 : cnt_q + CW'(1);
          if ((lane_byte == SYNC_WORD) && (match_q != MATCH_SAT)) begin
            match_d = match_q + MW'(1);
          end
        end
        S_EVAL: begin
          match_d = '0;
          if (match_q >= MATCH_MIN) begin
            if (cur_len_q == '0) cur_start_d = tap_q;
            cur_len_d = cur_len_q + LENW'(1);
            // Strict compare keeps the earliest window on equal length.
            if (cur_len_d > best_len_q) begin
              best_len_d   = cur_len_d;
              best_start_d = cur_start_d;
            end
          end else begin
            cur_len_d = '0;
          end
          if (tap_q == TAP_LAST) begin
            if (best_len_d >= EYE_MIN) begin
              centre = best_start_d + TAP_WIDTH'((best_len_d - LENW'(1)) >> 1);
            end else begin
              lane_fail_d[lane_q] = 1'b1;
            end
            tap_data_d[TAP_WIDTH*int'(lane_q) +: TAP_WIDTH] = centre;
`ifdef TAP_TRAIN_EYE_REPORT_EN
            eye_d[LENW*int'(lane_q) +: LENW] = best_len_d;
`endif
          end else begin
            tap_d = tap_q + TAP_WIDTH'(1);
            tap_data_d[TAP_WIDTH*int'(lane_q) +: TAP_WIDTH] = tap_d;
          end
        end
        S_FINAL: begin
          match_d      = '0;
          cur_start_d  = '0;
          cur_len_d    = '0;
          best_start_d = '0;
          best_len_d   = '0;
          if (lane_q != LANE_LAST) begin
            lane_d = lane_q + LW'(1);
            tap_d  = '0;
            tap_data_d[TAP_WIDTH*int'(lane_d) +: TAP_WIDTH] = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q       <= '0;
      tap_q        <= '0;
      cnt_q        <= '0;
      match_q      <= '0;
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      tap_data_q   <= '0;
      lane_fail_q  <= '0;
    end else begin
      lane_q       <= lane_d;
      tap_q        <= tap_d;
      cnt_q        <= cnt_d;
      match_q      <= match_d;
      cur_start_q  <= cur_start_d;
      cur_len_q    <= cur_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      tap_data_q   <= tap_data_d;
      lane_fail_q  <= lane_fail_d;
    end
  end

`ifdef TAP_TRAIN_EYE_REPORT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eye_q <= '0;
    end else begin
      eye_q <= eye_d;
    end
  end
  assign o_eye_width = eye_q;
`endif

  assign o_tap_data  = tap_data_q;
  assign o_lane_fail = lane_fail_q;

endmodule

`default_nettype wire

// File: tb/tb_imx_tap_training_ctrl.sv
// ============================================================================
// tb_imx_tap_training_ctrl : randomized sweep stimulus against an eye-search model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_imx_tap_training_ctrl;

  localparam int LANES  = 2;
  localparam int TW     = 3;
  localparam int NTAP   = 8;
  localparam int SETTLE = 4;
  localparam int SAMPLE = 16;
  localparam int MM     = 4;
  localparam int ME     = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 i_start = 1'b0;
  logic                 i_abort = 1'b0;
  logic [8*LANES-1:0]   i_raw_data = '0;
  logic [TW*LANES-1:0]  o_tap_data;
  logic                 o_tap_load;
  logic                 o_busy;
  logic                 o_done;
  logic [LANES-1:0]     o_lane_fail;
`ifdef TAP_TRAIN_EYE_REPORT_EN
  logic [(TW+1)*LANES-1:0] o_eye_width;
`endif

  imx_tap_training_ctrl #(
    .LANE_WIDTH(LANES), .TAP_WIDTH(TW), .SETTLE_CYCLES(SETTLE),
    .SAMPLE_CYCLES(SAMPLE), .MIN_MATCHES(MM), .MIN_EYE(ME), .SYNC_WORD(8'h7F)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
    .i_raw_data(i_raw_data), .o_tap_data(o_tap_data), .o_tap_load(o_tap_load),
    .o_busy(o_busy), .o_done(o_done),
`ifdef TAP_TRAIN_EYE_REPORT_EN
    .o_eye_width(o_eye_width),
`endif
    .o_lane_fail(o_lane_fail)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int hits [LANES][NTAP];
  int exp_tap [LANES];
  int exp_len [LANES];
  bit exp_fail [LANES];
  int idx = 100;
  int off = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Each lane emits SYNC on hits[lane][tap] of the sampled cycles; settle/eval cycles are noise.
  always @(negedge clk) begin
    if (o_tap_load) begin
      idx = 0;
      off = $urandom_range(0, SAMPLE - 1);
    end else if (idx < 100) begin
      idx++;
    end
    for (int n = 0; n < LANES; n++) begin
      logic [TW-1:0] tf;
      logic [7:0]    b;
      int            j;
      tf = o_tap_data[TW*n +: TW];
      b  = 8'($urandom);
      if ($urandom_range(0, 1) == 1) b = 8'h7F;
      j  = idx - (1 + SETTLE);
      if (j >= 0 && j < SAMPLE) begin
        if (((j + off) % SAMPLE) < hits[n][tf]) b = 8'h7F;
        else if (b == 8'h7F) b = 8'h00;
      end
      i_raw_data[8*n +: 8] = b;
    end
  end

  // Longest all-pass run, earliest start on ties, found by exhaustive search.
  task automatic model();
    for (int n = 0; n < LANES; n++) begin
      int blen, bstart;
      blen = 0; bstart = 0;
      for (int len = NTAP; len >= 1 && blen == 0; len--) begin
        for (int s = 0; s + len <= NTAP && blen == 0; s++) begin
          bit ok;
          ok = 1'b1;
          for (int t = s; t < s + len; t++) if (hits[n][t] < MM) ok = 1'b0;
          if (ok) begin blen = len; bstart = s; end
        end
      end
      exp_len[n]  = blen;
      exp_fail[n] = (blen < ME);
      exp_tap[n]  = exp_fail[n] ? 0 : bstart + (blen - 1) / 2;
    end
  endtask

  task automatic set_mask(input int n, input logic [NTAP-1:0] m);
    for (int t = 0; t < NTAP; t++)
      hits[n][t] = m[t] ? $urandom_range(MM, SAMPLE) : $urandom_range(0, MM - 1);
  endtask

  task automatic run_train(input string tag, input bit poke_start);
    int busy_n, done_n, load_n, cyc;
    bit seen;
    logic [TW*LANES-1:0] etap;
    logic [LANES-1:0]    efail;
    busy_n = 0; done_n = 0; load_n = 0; cyc = 0; seen = 0;
    model();
    etap = '0; efail = '0;
    for (int n = 0; n < LANES; n++) begin
      etap[TW*n +: TW] = TW'(exp_tap[n]);
      efail[n] = exp_fail[n];
    end
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    while (!seen && cyc < 2000) begin
      if (o_busy) busy_n++;
      if (o_tap_load) load_n++;
      if (o_done) begin
        done_n++;
        seen = 1'b1;
        check({tag, " busy_at_done"}, o_busy, 0);
      end
      i_start = (poke_start && cyc == 50);
      cyc++;
      @(negedge clk);
    end
    i_start = 1'b0;
    check({tag, " done_seen"}, seen, 1);
    for (int k = 0; k < 30; k++) begin
      if (o_done) done_n++;
      @(negedge clk);
    end
    check({tag, " done_count"}, done_n, 1);
    check({tag, " busy_cycles"}, busy_n, 2 * (NTAP * (2 + SETTLE + SAMPLE) + 1));
    check({tag, " load_count"}, load_n, LANES * (NTAP + 1));
    check({tag, " tap_data"}, o_tap_data, etap);
    check({tag, " lane_fail"}, o_lane_fail, efail);
`ifdef TAP_TRAIN_EYE_REPORT_EN
    begin
      logic [(TW+1)*LANES-1:0] eeye;
      for (int n = 0; n < LANES; n++) eeye[(TW+1)*n +: TW+1] = (TW+1)'(exp_len[n]);
      check({tag, " eye_width"}, o_eye_width, eeye);
    end
`endif
  endtask

  initial begin
    int cyc, loads;
    for (int n = 0; n < LANES; n++) for (int t = 0; t < NTAP; t++) hits[n][t] = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst tap_data", o_tap_data, 0);
    check("rst busy", o_busy, 0);
    check("rst done", o_done, 0);
    check("rst tap_load", o_tap_load, 0);
    check("rst lane_fail", o_lane_fail, 0);

    set_mask(0, 8'b0011_1100); set_mask(1, 8'hFF);
    run_train("s1_basic", 1'b1);

    set_mask(0, 8'b0111_0011); set_mask(1, 8'b1110_1110);
    run_train("s2_windows", 1'b0);

    set_mask(0, 8'b1100_0000); set_mask(1, 8'b0001_1100);
    run_train("s3_narrow", 1'b0);

    hits[0] = '{0, 1, 3, 4, 4, 4, 3, 2};
    hits[1] = '{2, 4, 4, 4, 3, 4, 4, 0};
    run_train("s4_threshold", 1'b0);

    for (int r = 0; r < 6; r++) begin
      set_mask(0, 8'($urandom) | 8'($urandom));
      set_mask(1, 8'($urandom) | 8'($urandom));
      run_train("rand", 1'b0);
    end

    @(negedge clk); i_start = 1'b1; i_abort = 1'b1;
    @(negedge clk); i_start = 1'b0; i_abort = 1'b0;
    check("abort_start_idle busy", o_busy, 0);

    set_mask(0, 8'b0011_1100); set_mask(1, 8'hFF);
    model();
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    cyc = 0; loads = 0;
    while (loads < NTAP + 2 && cyc < 1000) begin
      if (o_tap_load) loads++;
      cyc++;
      @(negedge clk);
    end
    check("s5 reached_lane1", loads, NTAP + 2);
    repeat (9) @(negedge clk);
    i_abort = 1'b1;
    @(negedge clk); i_abort = 1'b0;
    check("s5 busy_after_abort", o_busy, 0);
    loads = 0; cyc = 0;
    for (int k = 0; k < 400; k++) begin
      if (o_tap_load) loads++;
      if (o_done) cyc++;
      @(negedge clk);
    end
    check("s5 no_load", loads, 0);
    check("s5 no_done", cyc, 0);
    check("s5 tap_hold", o_tap_data, {3'd0, TW'(exp_tap[0])});

    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    repeat (100) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("s6 rst tap_data", o_tap_data, 0);
    check("s6 rst busy", o_busy, 0);
    check("s6 rst tap_load", o_tap_load, 0);
    check("s6 rst done", o_done, 0);
    check("s6 rst lane_fail", o_lane_fail, 0);
`ifdef TAP_TRAIN_EYE_REPORT_EN
    check("s6 rst eye", o_eye_width, 0);
`endif
    @(negedge clk); rst = 1'b0;
    run_train("s6_rerun", 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
